sync_feeder: RTL

Source-domain transmit scheduler that feeds the valid/data toggle synchronizer. It accepts words from upstream over a ready/valid handshake and buffers them in a small FIFO. It issues each word as a single-cycle `tx_valid` pulse with stable `tx_data`, and paces pulses so the destination domain observes every toggle before the synchronizer's data holding register is overwritten. The synchronizer itself has no back-pressure, so this block enforces the spacing rule.

---
 rtl/sync_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sync_feeder.sv
// sync_feeder: source-domain transmit scheduler for the valid/data toggle
// synchronizer. Buffers upstream words in a small FIFO and releases them as
// single-cycle tx_valid pulses that are spaced far enough apart for the
// destination domain to see every toggle.
//
// Build options:
//   SYNC_FEEDER_ACK_EN - adds the 'ack' input; WAIT is left on ack instead of
//                        after the MIN_GAP spacing count.
//   DATA_SYNC_WIDTH    - default payload width (8 if not supplied).

`ifndef DATA_SYNC_WIDTH
`define DATA_SYNC_WIDTH 8
`endif

module sync_feeder #(
    parameter int DATA_WIDTH = `DATA_SYNC_WIDTH,
    parameter int DEPTH      = 4,
    parameter int MIN_GAP    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef SYNC_FEEDER_ACK_EN
    input  logic                         ack,
`endif
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         tx_valid,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic                    full;
    logic                    push;

`ifndef SYNC_FEEDER_ACK_EN
    localparam int GW = $clog2(MIN_GAP);
    logic [GW-1:0]           gap_cnt;
`endif

    // The extra pointer MSB lets occupancy reach DEPTH without aliasing to empty.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign s_ready = !full && !rst;
    assign push    = s_valid && s_ready;
    assign busy    = (state != IDLE) || (level != '0);

    // Write side of the FIFO: store the word and advance the write pointer on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
            wr_ptr              <= wr_ptr + LW'(1);
        end
    end

    // Pulse scheduler: pop into tx_data, emit one pulse, then hold off before the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rd_ptr   <= '0;
`ifndef SYNC_FEEDER_ACK_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        tx_data  <= mem[rd_ptr[AW-1:0]];
                        rd_ptr   <= rd_ptr + LW'(1);
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_valid <= 1'b0;
`ifndef SYNC_FEEDER_ACK_EN
                    gap_cnt  <= GW'(MIN_GAP - 2);
`endif
                    state    <= WAIT;
                end
                WAIT: begin
`ifdef SYNC_FEEDER_ACK_EN
                    if (ack) begin
                        state <= IDLE;
                    end
`else
                    // Leaving on a count of 1 rather than 0 accounts for the
                    // IDLE cycle, so pulse-to-pulse spacing is exactly MIN_GAP.
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
`endif
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
